// File: rtl/dequant_ctrl_pkg.sv
// Shared types and constants for the dequant parameter-fetch sequencer.
package dequant_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StParam,
        StSettle,
        StWeight,
        StBias,
        StDrain,
        StDone
    } state_e;

    localparam int unsigned PARAM_WORDS   = 4;
    localparam int unsigned SETTLE_CYCLES = 1;

endpackage

// File: rtl/dequant_ctrl.sv
// Fetches one layer's scale/offset words, then streams quantized weights and biases
// through dequant with a one-stage pipe aligning write controls to the returning data.
module dequant_ctrl
    import dequant_ctrl_pkg::*;
#(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned QWIDTH = 8,
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned CWIDTH = 10
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [CWIDTH-1:0] n_weight,
    input  logic [CWIDTH-1:0] n_bias,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic [DWIDTH-1:0] w_scale,
    output logic [DWIDTH-1:0] w_offset,
    output logic [DWIDTH-1:0] b_scale,
    output logic [DWIDTH-1:0] b_offset,
    output logic              which,
    output logic [QWIDTH-1:0] deq_x,
    output logic              out_we,
    output logic [CWIDTH-1:0] out_addr,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic [AWIDTH-1:0] addr_q;
    logic [CWIDTH-1:0] nw_q, nb_q;
    logic              pcap_vld_q;
    logic [1:0]        pcap_idx_q;
    logic              we_q, which_q;
    logic [CWIDTH-1:0] out_addr_q;
    logic [DWIDTH-1:0] w_scale_q, w_offset_q, b_scale_q, b_offset_q;
    logic              accept, issue;

    assign accept = (state_q == StIdle) && req;
    assign issue  = (state_q == StParam) || (state_q == StWeight) || (state_q == StBias);

    // cnt_q counts cycles spent in the current state and is cleared on every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StParam;
                    cnt_d   = '0;
                end
            end
            StParam: begin
                if (cnt_q == CWIDTH'(PARAM_WORDS - 1)) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSettle: begin
                if (cnt_q == CWIDTH'(SETTLE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (nw_q != '0)      state_d = StWeight;
                    else if (nb_q != '0) state_d = StBias;
                    else                 state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWeight: begin
                if (cnt_q == nw_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = (nb_q != '0) ? StBias : StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBias: begin
                if (cnt_q == nb_q - 1'b1) begin
                    cnt_d   = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            nw_q       <= '0;
            nb_q       <= '0;
            pcap_vld_q <= 1'b0;
            pcap_idx_q <= '0;
            we_q       <= 1'b0;
            which_q    <= 1'b0;
            out_addr_q <= '0;
            w_scale_q  <= '0;
            w_offset_q <= '0;
            b_scale_q  <= '0;
            b_offset_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pcap_vld_q <= (state_q == StParam);
            we_q       <= (state_q == StWeight) || (state_q == StBias);
            which_q    <= (state_q == StBias);
            if (accept) begin
                addr_q     <= base_addr;
                nw_q       <= n_weight;
                nb_q       <= n_bias;
                pcap_idx_q <= '0;
                out_addr_q <= '0;
            end else begin
                if (issue) addr_q <= addr_q + 1'b1;
                if (we_q)  out_addr_q <= out_addr_q + 1'b1;
            end
            // Parameter words arrive one cycle after their PARAM issue, in address order.
            if (pcap_vld_q) begin
                pcap_idx_q <= pcap_idx_q + 1'b1;
                unique case (pcap_idx_q)
                    2'd0: w_scale_q  <= mem_rdata;
                    2'd1: w_offset_q <= mem_rdata;
                    2'd2: b_scale_q  <= mem_rdata;
                    2'd3: b_offset_q <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr = addr_q;
    assign w_scale  = w_scale_q;
    assign w_offset = w_offset_q;
    assign b_scale  = b_scale_q;
    assign b_offset = b_offset_q;
    assign which    = which_q;
    assign deq_x    = mem_rdata[QWIDTH-1:0];
    assign out_we   = we_q;
    assign out_addr = out_addr_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_dequant_ctrl.sv
// Randomized bench for dequant_ctrl against a cycle-indexed reference model of one layer.
module tb_dequant_ctrl;

    logic        clk = 1'b0;
    logic        xrst;
    logic        req;
    logic [11:0] base_addr;
    logic [9:0]  n_weight, n_bias;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] w_scale, w_offset, b_scale, b_offset;
    logic        which;
    logic [7:0]  deq_x;
    logic        out_we;
    logic [9:0]  out_addr;
    logic        busy, done;

    logic [15:0] mem [0:4095];
    logic [15:0] ys [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    dequant_ctrl dut (
        .clk       (clk),
        .xrst      (xrst),
        .req       (req),
        .base_addr (base_addr),
        .n_weight  (n_weight),
        .n_bias    (n_bias),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .w_scale   (w_scale),
        .w_offset  (w_offset),
        .b_scale   (b_scale),
        .b_offset  (b_offset),
        .which     (which),
        .deq_x     (deq_x),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Q8.8 scale times signed x, plus offset.
    function automatic logic [15:0] deq_y(input logic [15:0] s, input logic [15:0] o,
                                          input logic [7:0] x);
        logic signed [31:0] p;
        p = $signed(s) * $signed(x);
        return 16'(p >>> 8) + o;
    endfunction

    task automatic check_zero(input string tag);
        check_eq({tag, " mem_addr"}, 32'(mem_addr), 0);
        check_eq({tag, " w_scale"}, 32'(w_scale), 0);
        check_eq({tag, " w_offset"}, 32'(w_offset), 0);
        check_eq({tag, " b_scale"}, 32'(b_scale), 0);
        check_eq({tag, " b_offset"}, 32'(b_offset), 0);
        check_eq({tag, " which"}, 32'(which), 0);
        check_eq({tag, " out_we"}, 32'(out_we), 0);
        check_eq({tag, " out_addr"}, 32'(out_addr), 0);
        check_eq({tag, " busy"}, 32'(busy), 0);
        check_eq({tag, " done"}, 32'(done), 0);
    endtask

    // Drives one layer from cycle 0 and checks every cycle against the timing rules.
    task automatic run_layer(input logic [11:0] base, input int nw, input int nb,
                             input bit hold, input int abort_at, input bit log_y);
        int n;
        int k;
        logic [11:0] a;
        n = nw + nb;
        for (int c = 0; c <= 8 + n; c++) begin
            if (c == 0) begin
                @(posedge clk); #1;
                req = 1'b1; base_addr = base; n_weight = 10'(nw); n_bias = 10'(nb);
            end else begin
                @(posedge clk); #1;
                if (!hold || c >= 8 + n) req = 1'b0;
                base_addr = 12'($urandom); n_weight = 10'($urandom); n_bias = 10'($urandom);
            end
            if (c == abort_at) xrst = 1'b0;
            @(negedge clk);
            if (c == abort_at) begin
                check_zero("abort");
                @(posedge clk); #1;
                xrst = 1'b1; req = 1'b0;
                @(negedge clk);
                check_eq("abort no done", 32'(done), 0);
                check_eq("abort idle", 32'(busy), 0);
                return;
            end
            check_eq("busy", 32'(busy), 32'((c >= 1 && c <= 7 + n) ? 1 : 0));
            check_eq("done", 32'(done), 32'((c == 7 + n) ? 1 : 0));
            if (c >= 1 && c <= 4) check_eq("param addr", 32'(mem_addr), 32'(12'(base + c - 1)));
            if (c >= 6 && c <= 5 + n) check_eq("data addr", 32'(mem_addr), 32'(12'(base + c - 2)));
            check_eq("out_we", 32'(out_we), 32'((c >= 7 && c <= 6 + n) ? 1 : 0));
            if (c >= 7 && c <= 6 + n) begin
                k = c - 7;
                a = 12'(base + 4 + k);
                check_eq("which", 32'(which), 32'((k >= nw) ? 1 : 0));
                check_eq("out_addr", 32'(out_addr), 32'(k));
                check_eq("deq_x", 32'(deq_x), 32'(mem[a][7:0]));
                if (log_y) ys.push_back(which ? deq_y(b_scale, b_offset, deq_x)
                                              : deq_y(w_scale, w_offset, deq_x));
            end
            if (c >= 6) begin
                check_eq("w_scale", 32'(w_scale), 32'(mem[base]));
                check_eq("w_offset", 32'(w_offset), 32'(mem[12'(base + 1)]));
                check_eq("b_scale", 32'(b_scale), 32'(mem[12'(base + 2)]));
                check_eq("b_offset", 32'(b_offset), 32'(mem[12'(base + 3)]));
            end
        end
    endtask

    initial begin
        logic [15:0] exp_y [4];
        exp_y[0] = 16'h0012; exp_y[1] = 16'h000F; exp_y[2] = 16'h0014; exp_y[3] = 16'hFFF6;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[12'h100] = 16'h0100; mem[12'h101] = 16'h0010;
        mem[12'h102] = 16'h0200; mem[12'h103] = 16'hFFF0;
        mem[12'h104] = 16'h0002; mem[12'h105] = 16'h00FF;
        mem[12'h106] = 16'h0004; mem[12'h107] = 16'h0003;
        xrst = 1'b0; req = 1'b0; base_addr = '0; n_weight = '0; n_bias = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        xrst = 1'b1;

        run_layer(12'h100, 3, 1, 1'b0, -1, 1'b1);
        check_eq("y count", 32'(ys.size()), 4);
        for (int i = 0; i < 4 && i < ys.size(); i++) check_eq("dequant y", 32'(ys[i]), 32'(exp_y[i]));

        run_layer(12'h200, 0, 2, 1'b0, -1, 1'b0);
        run_layer(12'h300, 0, 0, 1'b0, -1, 1'b0);
        run_layer(12'h100, 3, 1, 1'b1, -1, 1'b0);
        run_layer(12'h180, 2, 2, 1'b0, -1, 1'b0);
        run_layer(12'h100, 3, 1, 1'b0, 8, 1'b0);
        run_layer(12'h100, 3, 1, 1'b0, -1, 1'b0);
        run_layer(12'hFFE, 2, 0, 1'b0, -1, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_layer(12'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                      1'($urandom), -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
